// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared constants, cell codes, direction encodings and FSM states for win_checker
//
// Purpose : board geometry, cell code for an empty square, scan direction
//           encodings and the controller state type.
// Ports   : none (package)
package win_pkg;

  localparam int ROWS    = 7;
  localparam int COLS    = 7;
  localparam int CELL_W  = 2;
  localparam int WIN_LEN = 4;
  localparam int NCELLS  = ROWS * COLS;
  localparam int BOARD_W = NCELLS * CELL_W;

  localparam logic [5:0] LAST_ANCHOR = 6'(NCELLS - 1);

  localparam logic [CELL_W-1:0] EMPTY = 2'b00;

  // Scan directions, in the order they are visited for each anchor
  localparam logic [1:0] DIR_H = 2'd0;  // +col
  localparam logic [1:0] DIR_V = 2'd1;  // +row
  localparam logic [1:0] DIR_D = 2'd2;  // +row,+col
  localparam logic [1:0] DIR_A = 2'd3;  // +row,-col

  // Linear-index step between consecutive cells of a run, per direction
  localparam logic [5:0] OFF_H = 6'd1;
  localparam logic [5:0] OFF_V = 6'(COLS);
  localparam logic [5:0] OFF_D = 6'(COLS + 1);
  localparam logic [5:0] OFF_A = 6'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/win_checker_line_match4.sv
// rtl/win_checker_line_match4.sv - combinational four-cell equality test for one candidate run
//
// Purpose : flags a run of four identical non-empty cells and reports its code.
// Ports   : i_c0..i_c3  four cell codes along the run
//           o_match     all four equal and non-empty
//           o_code      run code when matched, EMPTY otherwise
module line_match4
  import win_pkg::*;
(
  input  logic [CELL_W-1:0] i_c0,
  input  logic [CELL_W-1:0] i_c1,
  input  logic [CELL_W-1:0] i_c2,
  input  logic [CELL_W-1:0] i_c3,
  output logic              o_match,
  output logic [CELL_W-1:0] o_code
);

  always_comb begin
    o_match = (i_c0 != EMPTY) && (i_c0 == i_c1) && (i_c1 == i_c2) && (i_c2 == i_c3);
    o_code  = o_match ? i_c0 : EMPTY;
  end

endmodule

// File: rtl/win_checker.sv
// rtl/win_checker.sv - serial four-in-a-row / draw detector over a latched 7x7 board snapshot
//
// Purpose : on start, latches the board and checks one (anchor, direction)
//           pair per cycle; posts the first winning run or a draw verdict.
// Ports   : CLOCK_50  system clock
//           resetn    asynchronous active-low reset
//           board     98-bit board, cell 7*row+col at bits [2a+1:2a]
//           start     one-cycle request, board valid in the same cycle
//           busy      high while scanning
//           done      one-cycle pulse when a result is posted
//           win       four-in-a-row found
//           draw      no win and no empty cell
//           winner    code of the winning run (00 if none)
//           win_row   anchor row of the winning run
//           win_col   anchor column of the winning run
//           win_dir   direction of the winning run
module win_checker
  import win_pkg::*;
(
  input  logic               CLOCK_50,
  input  logic               resetn,
  input  logic [BOARD_W-1:0] board,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               win,
  output logic               draw,
  output logic [CELL_W-1:0]  winner,
  output logic [2:0]         win_row,
  output logic [2:0]         win_col,
  output logic [1:0]         win_dir
);

  state_t             r_state;
  logic [BOARD_W-1:0] r_snap;
  logic               r_has_empty;

  logic [5:0]         r_anchor;
  logic [1:0]         r_dir;
  logic [2:0]         r_row;
  logic [2:0]         r_col;

  // The check outcome is registered first and acted on one cycle later;
  // this fixes the result edge at T+2+k.
  logic               r_hit_q;
  logic               r_end_q;
  logic [CELL_W-1:0]  r_hit_code;
  logic [2:0]         r_hit_row;
  logic [2:0]         r_hit_col;
  logic [1:0]         r_hit_dir;

  logic               w_has_empty;
  logic               w_in_range;
  logic [5:0]         w_base;
  logic [5:0]         w_off;
  logic [5:0]         w_i1;
  logic [5:0]         w_i2;
  logic [5:0]         w_i3;
  logic [CELL_W-1:0]  w_c0;
  logic [CELL_W-1:0]  w_c1;
  logic [CELL_W-1:0]  w_c2;
  logic [CELL_W-1:0]  w_c3;
  logic               w_match;
  logic [CELL_W-1:0]  w_code;
  logic               w_hit;
  logic               w_last_check;

  function automatic logic [CELL_W-1:0] cell_at(input logic [BOARD_W-1:0] s,
                                                input logic [5:0]         idx);
    return s[{idx, 1'b0} +: CELL_W];
  endfunction

  always_comb begin
    w_has_empty = 1'b0;
    for (int a = 0; a < NCELLS; a++) begin
      if (board[CELL_W*a +: CELL_W] == EMPTY) w_has_empty = 1'b1;
    end
  end

  // Out-of-range combinations use a zero step so every fetched index stays
  // on the board (max 48); their result is masked by w_in_range anyway.
  always_comb begin
    w_in_range = 1'b0;
    w_off      = 6'd0;
    case (r_dir)
      DIR_H: begin w_in_range = (r_col <= 3'd3);                    w_off = OFF_H; end
      DIR_V: begin w_in_range = (r_row <= 3'd3);                    w_off = OFF_V; end
      DIR_D: begin w_in_range = (r_row <= 3'd3) && (r_col <= 3'd3); w_off = OFF_D; end
      default: begin w_in_range = (r_row <= 3'd3) && (r_col >= 3'd3); w_off = OFF_A; end
    endcase
    if (!w_in_range) w_off = 6'd0;
  end

  always_comb begin
    w_base = 6'd7 * {3'b000, r_row} + {3'b000, r_col};
    w_i1   = w_base + w_off;
    w_i2   = w_i1 + w_off;
    w_i3   = w_i2 + w_off;
    w_c0   = cell_at(r_snap, w_base);
    w_c1   = cell_at(r_snap, w_i1);
    w_c2   = cell_at(r_snap, w_i2);
    w_c3   = cell_at(r_snap, w_i3);
  end

  line_match4 u_match (
    .i_c0    (w_c0),
    .i_c1    (w_c1),
    .i_c2    (w_c2),
    .i_c3    (w_c3),
    .o_match (w_match),
    .o_code  (w_code)
  );

  assign w_hit        = w_in_range && w_match;
  assign w_last_check = (r_anchor == LAST_ANCHOR) && (r_dir == DIR_A);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_has_empty <= 1'b0;
      r_anchor    <= '0;
      r_dir       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_hit_q     <= 1'b0;
      r_end_q     <= 1'b0;
      r_hit_code  <= '0;
      r_hit_row   <= '0;
      r_hit_col   <= '0;
      r_hit_dir   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      win         <= 1'b0;
      draw        <= 1'b0;
      winner      <= '0;
      win_row     <= '0;
      win_col     <= '0;
      win_dir     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_snap      <= board;
            r_has_empty <= w_has_empty;
            r_anchor    <= '0;
            r_dir       <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_hit_q     <= 1'b0;
            r_end_q     <= 1'b0;
            busy        <= 1'b1;
            win         <= 1'b0;
            draw        <= 1'b0;
            winner      <= '0;
            win_row     <= '0;
            win_col     <= '0;
            win_dir     <= '0;
            r_state     <= SCAN;
          end
        end

        SCAN: begin
          if (r_hit_q) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            win     <= 1'b1;
            winner  <= r_hit_code;
            win_row <= r_hit_row;
            win_col <= r_hit_col;
            win_dir <= r_hit_dir;
            r_state <= DONE;
          end else if (r_end_q) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            draw    <= ~r_has_empty;
            r_state <= DONE;
          end else begin
            if (w_hit) begin
              r_hit_q    <= 1'b1;
              r_hit_code <= w_code;
              r_hit_row  <= r_row;
              r_hit_col  <= r_col;
              r_hit_dir  <= r_dir;
            end
            if (w_last_check) r_end_q <= 1'b1;
            r_dir <= r_dir + 2'd1;
            // Anchor advances after its last direction; saturates on the final cell
            if ((r_dir == DIR_A) && (r_anchor != LAST_ANCHOR)) begin
              r_anchor <= r_anchor + 6'd1;
              if (r_col == 3'(COLS - 1)) begin
                r_col <= '0;
                r_row <= r_row + 3'd1;
              end else begin
                r_col <= r_col + 3'd1;
              end
            end
          end
        end

        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_win_checker.sv
// tb/tb_win_checker.sv - scoreboard testbench for win_checker
module tb_win_checker;
  import win_pkg::*;

  typedef struct {
    logic       win;
    logic       draw;
    logic [1:0] winner;
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] dir;
    int         cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [97:0] board;
  logic        start;
  logic        busy;
  logic        done;
  logic        win;
  logic        draw;
  logic [1:0]  winner;
  logic [2:0]  win_row;
  logic [2:0]  win_col;
  logic [1:0]  win_dir;

  int          cyc;
  int          n_pass;
  int          n_total;
  logic        prev_done;
  logic [97:0] b;
  exp_t        sb[$];
  exp_t        last_exp;

  win_checker dut (
    .CLOCK_50 (clk),
    .resetn   (rst_n),
    .board    (board),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .win      (win),
    .draw     (draw),
    .winner   (winner),
    .win_row  (win_row),
    .win_col  (win_col),
    .win_dir  (win_dir)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: pops one expectation per done pulse
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (prev_done) chk("done_single_cycle", int'(done), 0);
    if (done) begin
      chk("done_expected", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("done_time",   cyc,          e.cyc);
        chk("busy_at_done", int'(busy),  0);
        chk("win",         int'(win),     int'(e.win));
        chk("draw",        int'(draw),    int'(e.draw));
        chk("winner",      int'(winner),  int'(e.winner));
        chk("win_row",     int'(win_row), int'(e.row));
        chk("win_col",     int'(win_col), int'(e.col));
        chk("win_dir",     int'(win_dir), int'(e.dir));
      end
    end
    prev_done = done;
  end

  task automatic set_cell(input int r, input int c, input logic [1:0] v);
    b[2*(7*r+c) +: 2] = v;
  endtask

  // Issues a start at the next edge; k is the index of the deciding check
  task automatic issue(input bit push, input int k, input logic w, input logic d,
                       input logic [1:0] wn, input logic [2:0] r, input logic [2:0] c,
                       input logic [1:0] dr);
    exp_t e;
    @(negedge clk);
    board = b;
    start = 1'b1;
    e.win = w; e.draw = d; e.winner = wn; e.row = r; e.col = c; e.dir = dr;
    e.cyc = cyc + 3 + k;
    if (push) begin
      sb.push_back(e);
      last_exp = e;
    end
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("win_cleared_on_start", int'(win), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("win_held",    int'(win),    int'(last_exp.win));
    chk("winner_held", int'(winner), int'(last_exp.winner));
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    board   = '0;
    b       = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_done",    int'(done),    0);
    chk("rst_win",     int'(win),     0);
    chk("rst_draw",    int'(draw),    0);
    chk("rst_winner",  int'(winner),  0);
    chk("rst_row",     int'(win_row), 0);
    chk("rst_col",     int'(win_col), 0);
    chk("rst_dir",     int'(win_dir), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All-empty board: full scan, no win, not a draw
    b = '0;
    issue(1, 195, 0, 0, 2'b00, 3'd0, 3'd0, 2'd0);
    repeat (195) @(negedge clk);
    chk("busy_before_last", int'(busy), 1);
    chk("no_early_done",    int'(done), 0);
    drain();

    // Bottom row horizontal, anchor 42
    b = '0;
    for (int c = 0; c < 4; c++) set_cell(6, c, 2'b01);
    issue(1, 168, 1, 0, 2'b01, 3'd6, 3'd0, 2'd0);
    drain();

    // Anti-diagonal from (0,3), anchor 3 dir 3
    b = '0;
    set_cell(0, 3, 2'b10); set_cell(1, 2, 2'b10); set_cell(2, 1, 2'b10); set_cell(3, 0, 2'b10);
    issue(1, 15, 1, 0, 2'b10, 3'd0, 3'd3, 2'd3);
    drain();

    // Full board with no run longer than two: draw
    b = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        set_cell(r, c, (((r + 2*c) % 4) < 2) ? 2'b01 : 2'b10);
    issue(1, 195, 0, 1, 2'b00, 3'd0, 3'd0, 2'd0);
    drain();

    // Diagonal of code 11 from (2,1), anchor 15 dir 2
    b = '0;
    for (int i = 0; i < 4; i++) set_cell(2 + i, 1 + i, 2'b11);
    issue(1, 62, 1, 0, 2'b11, 3'd2, 3'd1, 2'd2);
    drain();

    // Two runs: vertical at column 6 is found first (k=25)
    b = '0;
    for (int i = 0; i < 4; i++) set_cell(i, 6, 2'b01);
    for (int c = 0; c < 4; c++) set_cell(6, c, 2'b10);
    issue(1, 25, 1, 0, 2'b01, 3'd0, 3'd6, 2'd1);
    drain();

    // Vertical at column 2; second start at T+5 with another board is ignored
    b = '0;
    for (int r = 3; r < 7; r++) set_cell(r, 2, 2'b01);
    issue(1, 93, 1, 0, 2'b01, 3'd3, 3'd2, 2'd1);
    repeat (4) @(negedge clk);
    b = '0;
    for (int c = 0; c < 4; c++) set_cell(0, c, 2'b10);
    board = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_second_start", int'(busy), 1);
    drain();

    // Reset mid-scan aborts with no done; a fresh start then completes
    b = '0;
    for (int r = 3; r < 7; r++) set_cell(r, 2, 2'b01);
    issue(0, 93, 1, 0, 2'b01, 3'd3, 3'd2, 2'd1);
    repeat (48) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy",   int'(busy),    0);
    chk("abort_done",   int'(done),    0);
    chk("abort_win",    int'(win),     0);
    chk("abort_winner", int'(winner),  0);
    chk("abort_row",    int'(win_row), 0);
    chk("abort_col",    int'(win_col), 0);
    chk("abort_dir",    int'(win_dir), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("idle_after_abort", int'(busy), 0);
    issue(1, 93, 1, 0, 2'b01, 3'd3, 3'd2, 2'd1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
